// File: rtl/fp_normalizer.sv
// Iterative mantissa normaliser: one shift per cycle between the add/sub and rounding stages.
// Right-shifts once on carry-out, left-shifts until the hidden bit is set, then classifies the result.
module fp_normalizer #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [FRAC_W+1:0] in_mant,
  input  logic              in_sticky,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  out_exp,
  output logic [FRAC_W-1:0] out_frac,
  output logic              out_sticky,
  output logic              out_zero,
  output logic              out_subnormal,
  output logic              out_overflow
);

  localparam int unsigned MANT_W = FRAC_W + 2;

  typedef enum logic [1:0] {StIdle, StNorm, StDone} state_e;

  state_e              r_state, w_state_nxt;
  logic [EXP_W-1:0]    r_exp, w_exp_nxt, w_exp_inc;
  logic [MANT_W-1:0]   r_mant, w_mant_nxt;
  logic                r_sticky, w_sticky_nxt;
  logic                r_zero, w_zero_nxt;
  logic                r_sub, w_sub_nxt;
  logic                r_ovf, w_ovf_nxt;

  assign w_exp_inc = r_exp + EXP_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_exp_nxt    = r_exp;
    w_mant_nxt   = r_mant;
    w_sticky_nxt = r_sticky;
    w_zero_nxt   = r_zero;
    w_sub_nxt    = r_sub;
    w_ovf_nxt    = r_ovf;
    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_exp_nxt    = in_exp;
          w_mant_nxt   = in_mant;
          w_sticky_nxt = in_sticky;
          w_zero_nxt   = 1'b0;
          w_sub_nxt    = 1'b0;
          w_ovf_nxt    = 1'b0;
          w_state_nxt  = StNorm;
        end
      end
      StNorm: begin
        // Exponent can only reach all-ones via overflow (which exits at once), so this is Inf/NaN.
        if (r_exp == '1) begin
          w_state_nxt = StDone;
        end else if (r_mant == '0) begin
          w_exp_nxt   = '0;
          w_zero_nxt  = 1'b1;
          w_state_nxt = StDone;
        end else if (r_mant[MANT_W-1]) begin
          w_mant_nxt   = r_mant >> 1;
          w_sticky_nxt = r_sticky | r_mant[0];
          w_exp_nxt    = w_exp_inc;
          if (w_exp_inc == '1) begin
            w_mant_nxt  = '0;
            w_ovf_nxt   = 1'b1;
            w_state_nxt = StDone;
          end
        end else if (!r_mant[MANT_W-2]) begin
          if (r_exp > EXP_W'(1)) begin
            w_mant_nxt = r_mant << 1;
            w_exp_nxt  = r_exp - EXP_W'(1);
          end else begin
            w_exp_nxt   = '0;
            w_sub_nxt   = 1'b1;
            w_state_nxt = StDone;
          end
        end else begin
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp    <= '0;
      r_mant   <= '0;
      r_sticky <= 1'b0;
      r_zero   <= 1'b0;
      r_sub    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_exp    <= w_exp_nxt;
      r_mant   <= w_mant_nxt;
      r_sticky <= w_sticky_nxt;
      r_zero   <= w_zero_nxt;
      r_sub    <= w_sub_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

  always_comb begin
    in_ready      = (r_state == StIdle);
    out_valid     = (r_state == StDone);
    out_exp       = r_exp;
    out_frac      = r_mant[FRAC_W-1:0];
    out_sticky    = r_sticky;
    out_zero      = r_zero;
    out_subnormal = r_sub;
    out_overflow  = r_ovf;
  end

endmodule

// File: tb/tb_fp_normalizer.sv
// Scoreboard bench for fp_normalizer: driver pushes hand-computed results, monitor pops on out_valid.
module tb_fp_normalizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_exp = '0;
  logic [24:0] in_mant = '0;
  logic        in_sticky = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_exp;
  logic [22:0] out_frac;
  logic        out_sticky, out_zero, out_subnormal, out_overflow;

  fp_normalizer #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_exp(in_exp),
    .in_mant(in_mant), .in_sticky(in_sticky), .out_valid(out_valid), .out_ready(out_ready),
    .out_exp(out_exp), .out_frac(out_frac), .out_sticky(out_sticky), .out_zero(out_zero),
    .out_subnormal(out_subnormal), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  e;
    logic [22:0] f;
    logic        s, z, sub, ovf;
    int          lat;
    int          k;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: a result is new unless the previous one is still being held by back-pressure.
  initial begin : monitor
    exp_t cur;
    bit   holding = 1'b0;
    bit   accepted;
    forever begin
      @(posedge clk);
      accepted = out_valid && out_ready;
      #1;
      if (accepted || rst) holding = 1'b0;
      if (!rst && out_valid) begin
        if (!holding) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out_valid: got result exp=0x%0h with nothing expected", out_exp);
          end else begin
            cur = sb_q.pop_front();
            chk("latency", cyc - cur.k, cur.lat);
            chk("out_exp", out_exp, cur.e);
            chk("out_frac", out_frac, cur.f);
            chk("out_sticky", out_sticky, cur.s);
            chk("out_zero", out_zero, cur.z);
            chk("out_subnormal", out_subnormal, cur.sub);
            chk("out_overflow", out_overflow, cur.ovf);
          end
        end else begin
          chk("hold_exp", out_exp, cur.e);
          chk("hold_frac", out_frac, cur.f);
          chk("hold_flags", {out_sticky, out_zero, out_subnormal, out_overflow},
              {cur.s, cur.z, cur.sub, cur.ovf});
          chk("hold_in_ready", in_ready, 0);
        end
        holding = 1'b1;
      end
    end
  end

  task automatic send(input logic [7:0] e, input logic [24:0] m, input logic s,
                      input exp_t x, input bit push, output int k);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
    in_valid  = 1'b1;
    in_exp    = e;
    in_mant   = m;
    in_sticky = s;
    @(posedge clk);
    #1;
    k = cyc;
    x.k = cyc;
    if (push) sb_q.push_back(x);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb_q.size() != 0 || out_valid) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain", sb_q.size(), 0);
  endtask

  function automatic exp_t mk(input logic [7:0] e, input logic [22:0] f, input logic s,
                              input logic z, input logic sub, input logic ovf, input int lat);
    exp_t r;
    r.e = e; r.f = f; r.s = s; r.z = z; r.sub = sub; r.ovf = ovf; r.lat = lat; r.k = 0;
    return r;
  endfunction

  initial begin : driver
    int k, rel;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_exp", out_exp, 0);
    chk("rst_out_frac", out_frac, 0);
    chk("rst_flags", {out_sticky, out_zero, out_subnormal, out_overflow}, 0);
    @(negedge clk);
    rst = 1'b0;

    send(8'h80, 25'h0800000, 1'b0, mk(8'h80, 23'h0, 0, 0, 0, 0, 1), 1, k);        // normalised
    send(8'h7F, 25'h1000001, 1'b0, mk(8'h80, 23'h0, 1, 0, 0, 0, 2), 1, k);        // carry
    send(8'h80, 25'h0000001, 1'b0, mk(8'h69, 23'h0, 0, 0, 0, 0, 24), 1, k);       // deep left
    send(8'h03, 25'h0000100, 1'b0, mk(8'h00, 23'h000400, 0, 0, 1, 0, 3), 1, k);   // subnormal
    send(8'hFE, 25'h1000000, 1'b0, mk(8'hFF, 23'h0, 0, 0, 0, 1, 1), 1, k);        // overflow
    send(8'h45, 25'h0000000, 1'b1, mk(8'h00, 23'h0, 1, 1, 0, 0, 1), 1, k);        // zero
    send(8'hFF, 25'h0123456, 1'b0, mk(8'hFF, 23'h123456, 0, 0, 0, 0, 1), 1, k);  // Inf/NaN
    send(8'h10, 25'h1800003, 1'b0, mk(8'h11, 23'h400001, 1, 0, 0, 0, 2), 1, k);
    send(8'h01, 25'h0200000, 1'b0, mk(8'h00, 23'h200000, 0, 0, 1, 0, 1), 1, k);
    wait_drain();

    // Back-pressure: result held five cycles, then released.
    @(negedge clk);
    out_ready = 1'b0;
    send(8'h20, 25'h0200000, 1'b1, mk(8'h1E, 23'h0, 1, 0, 0, 0, 3), 1, k);
    begin
      int t = 0;
      while (!out_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk("bp_out_valid_seen", out_valid, 1);
    end
    repeat (5) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rel = cyc;
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
    send(8'h80, 25'h0C00000, 1'b0, mk(8'h80, 23'h400000, 0, 0, 0, 0, 1), 1, k);
    chk("accept_after_release", k - rel, 1);
    wait_drain();

    // Reset at the tenth shift of a deep left shift discards the operation.
    send(8'h80, 25'h0000001, 1'b0, mk(8'h0, 23'h0, 0, 0, 0, 0, 0), 0, k);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_exp", out_exp, 0);
    chk("midrst_out_frac", out_frac, 0);
    chk("midrst_flags", {out_sticky, out_zero, out_subnormal, out_overflow}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    send(8'h7F, 25'h1000000, 1'b1, mk(8'h80, 23'h0, 1, 0, 0, 0, 2), 1, k);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
